// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding and the sequential PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_t;

    localparam int PC_STEP = 1;

endpackage

// File: rtl/fetch_unit_pcreg.sv
// Fetch program-counter register.
// The value loads INIT on reset and loads d when en is high.
module fetch_unit_pcreg #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= INIT;
        end else if (en) begin
            r_pc <= d;
        end
    end

    assign q = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: issue request, wait for data,
// hold one instruction for decode; redirects retarget the PC in any state.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst_data,
    output logic [WIDTH-1:0] inst_pc,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0] fetch_pc
);

    fetch_state_t     r_state;
    fetch_state_t     w_next;
    logic [WIDTH-1:0] r_inst_data;
    logic [WIDTH-1:0] r_inst_pc;
    logic [WIDTH-1:0] w_fetch_pc;
    logic [WIDTH-1:0] w_pc_d;
    logic [WIDTH-1:0] w_pc_inc;
    logic             w_pc_en;
    logic             w_ld_pc;
    logic             w_ld_data;

    fetch_unit_pcreg #(
        .WIDTH (WIDTH),
        .INIT  (INIT)
    ) u_pcreg (
        .clk   (clk),
        .reset (reset),
        .en    (w_pc_en),
        .d     (w_pc_d),
        .q     (w_fetch_pc)
    );

    // Wraps naturally at 2^WIDTH since the sum is truncated to WIDTH bits.
    assign w_pc_inc = w_fetch_pc + WIDTH'(PC_STEP);

    always_comb begin
        w_next    = r_state;
        w_pc_en   = 1'b0;
        w_pc_d    = w_fetch_pc;
        w_ld_pc   = 1'b0;
        w_ld_data = 1'b0;
        if (redirect_valid) begin
            w_pc_en = 1'b1;
            w_pc_d  = redirect_target;
        end
        case (r_state)
            S_FETCH: begin
                if (imem_req_ready) begin
                    // A redirect racing the handshake leaves a stale request in flight.
                    w_next = redirect_valid ? S_DROP : S_WAIT;
                    if (!redirect_valid) begin
                        w_pc_en = 1'b1;
                        w_pc_d  = w_pc_inc;
                        w_ld_pc = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_next = imem_rsp_valid ? S_FETCH : S_DROP;
                end else if (imem_rsp_valid) begin
                    w_ld_data = 1'b1;
                    w_next    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid || inst_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    w_next = S_FETCH;
                end
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_inst_pc   <= INIT;
            r_inst_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_ld_pc) begin
                r_inst_pc <= w_fetch_pc;
            end
            if (w_ld_data) begin
                r_inst_data <= imem_rsp_data;
            end
        end
    end

    assign imem_req_valid = (r_state == S_FETCH);
    assign imem_req_addr  = w_fetch_pc;
    assign inst_valid     = (r_state == S_HOLD);
    assign inst_data      = r_inst_data;
    assign inst_pc        = r_inst_pc;
    assign fetch_pc       = w_fetch_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, hold stall, redirects,
// PC wrap and reset priority, with hand-computed expectations.
module tb_fetch_unit;

    localparam int          WIDTH = 16;
    localparam logic [15:0] INIT  = 16'h0100;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic [15:0] fetch_pc;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit #(.WIDTH(WIDTH), .INIT(INIT)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fetch_pc        (fetch_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full fetch of address a returning word d, decode accepting immediately.
    task automatic do_fetch(input logic [15:0] a, input logic [15:0] d);
        logic [15:0] nxt;
        nxt = a + 16'd1;
        chk("req_valid", {15'd0, imem_req_valid}, 16'd1);
        chk("req_addr", imem_req_addr, a);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("wait_no_req", {15'd0, imem_req_valid}, 16'd0);
        chk("pc_inc", fetch_pc, nxt);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        tick();
        imem_rsp_valid = 1'b0;
        chk("hold_valid", {15'd0, inst_valid}, 16'd1);
        chk("hold_data", inst_data, d);
        chk("hold_pc", inst_pc, a);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("post_nvalid", {15'd0, inst_valid}, 16'd0);
        chk("post_req", {15'd0, imem_req_valid}, 16'd1);
    endtask

    initial begin
        reset           = 1'b1;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 16'h0000;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 16'h0000;
        tick();
        tick();
        chk("rst_inst_valid", {15'd0, inst_valid}, 16'd0);
        chk("rst_inst_data", inst_data, 16'h0000);
        reset = 1'b0;
        chk("rst_req_valid", {15'd0, imem_req_valid}, 16'd1);
        chk("rst_req_addr", imem_req_addr, 16'h0100);
        chk("rst_inst_pc", inst_pc, 16'h0100);

        // Sequential fetches
        do_fetch(16'h0100, 16'hA001);
        do_fetch(16'h0101, 16'hA002);
        do_fetch(16'h0102, 16'hA003);

        // Decode stall in HOLD for 5 cycles
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 16'hBEEF;
        tick();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {15'd0, inst_valid}, 16'd1);
            chk("stall_data", inst_data, 16'hBEEF);
            chk("stall_pc", inst_pc, 16'h0103);
            chk("stall_no_req", {15'd0, imem_req_valid}, 16'd0);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("stall_release_addr", imem_req_addr, 16'h0104);

        // Redirect while waiting, response 3 cycles later is stale
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 16'h2000;
        tick();
        redirect_valid = 1'b0;
        chk("drop_pc", fetch_pc, 16'h2000);
        tick();
        chk("drop_no_req", {15'd0, imem_req_valid}, 16'd0);
        chk("drop_no_inst", {15'd0, inst_valid}, 16'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 16'hDEAD;
        tick();
        imem_rsp_valid = 1'b0;
        chk("stale_no_inst", {15'd0, inst_valid}, 16'd0);
        tick();
        chk("stale_still_no_inst", {15'd0, inst_valid}, 16'd0);
        do_fetch(16'h2000, 16'hC000);

        // Response arriving in FETCH is ignored
        imem_rsp_valid = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        chk("ign_rsp_nvalid", {15'd0, inst_valid}, 16'd0);
        chk("ign_rsp_req", {15'd0, imem_req_valid}, 16'd1);

        // Redirect without handshake, then PC wrap
        redirect_valid  = 1'b1;
        redirect_target = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        chk("redir_fetch_addr", imem_req_addr, 16'hFFFF);
        do_fetch(16'hFFFF, 16'h1234);
        chk("wrap_addr", imem_req_addr, 16'h0000);

        // Redirect racing the FETCH handshake
        imem_req_ready  = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 16'h0040;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        chk("race_pc", fetch_pc, 16'h0040);
        chk("race_no_req", {15'd0, imem_req_valid}, 16'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 16'hDEAD;
        tick();
        imem_rsp_valid = 1'b0;
        chk("race_no_inst", {15'd0, inst_valid}, 16'd0);
        chk("race_addr", imem_req_addr, 16'h0040);

        // Redirect in WAIT together with the response
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 16'h0300;
        imem_rsp_valid  = 1'b1;
        tick();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        chk("wr_no_inst", {15'd0, inst_valid}, 16'd0);
        chk("wr_req", {15'd0, imem_req_valid}, 16'd1);
        chk("wr_addr", imem_req_addr, 16'h0300);

        // Redirect in HOLD discards the buffer
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 16'h7777;
        tick();
        imem_rsp_valid  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 16'h0500;
        tick();
        redirect_valid = 1'b0;
        chk("hr_no_inst", {15'd0, inst_valid}, 16'd0);
        chk("hr_addr", imem_req_addr, 16'h0500);

        // Reset in HOLD overrides inst_ready and redirect
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 16'h5A5A;
        tick();
        imem_rsp_valid = 1'b0;
        chk("pre_rst_valid", {15'd0, inst_valid}, 16'd1);
        reset           = 1'b1;
        inst_ready      = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 16'h5555;
        tick();
        reset          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        chk("mrst_no_inst", {15'd0, inst_valid}, 16'd0);
        chk("mrst_req", {15'd0, imem_req_valid}, 16'd1);
        chk("mrst_pc", fetch_pc, 16'h0100);
        chk("mrst_inst_pc", inst_pc, 16'h0100);
        chk("mrst_inst_data", inst_data, 16'h0000);
        do_fetch(16'h0100, 16'hE0E0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WIDTH, default 16, address and instruction width in bits.
REQ-002 Parameter INIT, default 0 (WIDTH bits), fetch PC loaded on reset.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 imem_req_valid  out  1  fetch request present.
REQ-006 imem_req_ready  in  1  memory accepts request; transfer when valid&&ready.
REQ-007 imem_req_addr  out  WIDTH  word address of request.
REQ-008 imem_rsp_valid  in  1  read data valid, one cycle per accepted request.
REQ-009 imem_rsp_data  in  WIDTH  instruction word.
REQ-010 inst_valid  out  1  buffered instruction available to decode.
REQ-011 inst_ready  in  1  decode accepts; transfer when valid&&ready.
REQ-012 inst_data  out  WIDTH  buffered instruction.
REQ-013 inst_pc  out  WIDTH  address inst_data was fetched from.
REQ-014 redirect_valid  in  1  branch/jump taken this cycle.
REQ-015 redirect_target  in  WIDTH  new fetch address.
REQ-016 fetch_pc  out  WIDTH  current fetch PC.

Function
REQ-017 States SHALL be FETCH, WAIT, HOLD, DROP; at most one memory request outstanding.
REQ-018 FETCH: imem_req_valid=1, imem_req_addr=fetch_pc; on handshake: inst_pc<=fetch_pc, fetch_pc<=fetch_pc+1, ->WAIT.
REQ-019 PC increment SHALL be modulo 2^WIDTH (0xFFFF+1 -> 0x0000, no carry out).
REQ-020 WAIT: imem_req_valid=0; on imem_rsp_valid: inst_data<=imem_rsp_data, ->HOLD; response latency from acceptance SHALL be any value >=1 cycle.
REQ-021 HOLD: inst_valid=1, inst_data/inst_pc stable; on inst_ready ->FETCH (next request issued the following cycle).
REQ-022 inst_valid SHALL be 1 only in HOLD; imem_req_valid only in FETCH.
REQ-023 Redirect has priority over all other events: fetch_pc<=redirect_target in every state.
REQ-024 Redirect in FETCH without handshake: stay FETCH; with handshake same cycle: ->DROP (stale request), fetch_pc<=target (not +1).
REQ-025 Redirect in WAIT: if imem_rsp_valid same cycle discard data ->FETCH; else ->DROP.
REQ-026 Redirect in HOLD: buffer discarded, inst_valid=0 next cycle, ->FETCH; if inst_ready same cycle the transfer still counts as completed.
REQ-027 DROP: imem_req_valid=0, inst_valid=0; on imem_rsp_valid discard data ->FETCH; further redirects update fetch_pc, stay DROP.
REQ-028 imem_rsp_valid outside WAIT/DROP SHALL be ignored.

Reset
REQ-029 reset high at a clock edge: state<=FETCH, fetch_pc<=INIT, inst_pc<=INIT, inst_data<=0; overrides redirect and all handshakes.
REQ-030 During and after reset cycle: inst_valid=0; imem_req_valid=1 with addr INIT in the first cycle reset is low.
REQ-031 Reset mid-operation abandons any outstanding request; memory SHALL be reset concurrently.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum (fetch_state_t) and constant PC_STEP=1.
REQ-033 fetch_pc SHALL be held in one instance of the existing pc register sub-module (WIDTH, INIT passed through); the FSM drives its d/en.
REQ-034 Instruction buffer (inst_data, inst_pc) and state register are local flops.

Verification
REQ-035 Reset, INIT=0x0100, req_ready=1, 1-cycle rsp, inst_ready=1 -> requests 0x0100,0x0101,0x0102 in order; inst_pc matches each.
REQ-036 inst_ready=0 for 5 cycles in HOLD -> inst_valid, inst_data, inst_pc stable, no new request issued.
REQ-037 Redirect to 0x2000 in WAIT, rsp 3 cycles later -> response discarded, next request addr 0x2000, no inst_valid for stale data.
REQ-038 fetch_pc=0xFFFF, handshake -> fetch_pc=0x0000, next request addr 0x0000.
REQ-039 Redirect to 0x0040 same cycle as FETCH handshake -> DROP, stale response dropped, next request 0x0040.
REQ-040 reset asserted in HOLD with inst_ready=1 and redirect_valid=1 -> next cycle state FETCH, fetch_pc=INIT, inst_valid=0.
